// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported 256 x 16 data memory between two
// requesters (port 0 = CPU load/store unit, port 1 = DMA/debug loader).
// One access is sequenced at a time through a two-state IDLE/ACCESS FSM,
// giving at most one access every two cycles.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req*/we*/addr*/wdata*        per-port request, held until gnt is seen
//   gnt*                         one-cycle grant pulse (the ACCESS cycle)
//   rvalid*/err*                 one-cycle response pulse in the cycle after
//                                the grant
//   rdata                        captured read data, shared by both ports
//   busy                         high while in ACCESS
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  memory pins
module dmem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_l_q, we_l_d;
  logic        bad_l_q, bad_l_d;
  logic [15:0] addr_l_q, addr_l_d;
  logic [15:0] wdata_l_q, wdata_l_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        winner;
  logic        start;
  logic        in_access;

  // Misaligned, or outside the 512-byte memory window.
  function automatic logic addr_bad(input logic [15:0] a);
    return a[0] | (a[15:9] != 7'd0);
  endfunction

  // Arbitration: only consulted when both ports request in IDLE.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      if (PRIO_MODE == 0) winner = ~last_owner_q;
      else                winner = (wait_cnt_q >= MAX_WAIT_C);
    end
  end

  assign start     = (state_q == IDLE) && (req0 || req1);
  assign in_access = (state_q == ACCESS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ACCESS always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the memory bus is driven straight from the state flop, so an
  // asynchronous reset during ACCESS removes mem_write before the edge.
  always_comb begin
    busy      = in_access;
    gnt0      = in_access & ~owner_q;
    gnt1      = in_access &  owner_q;
    mem_read  = in_access & ~we_l_q & ~bad_l_q;
    mem_write = in_access &  we_l_q & ~bad_l_q;
    mem_addr  = in_access ? addr_l_q  : 16'h0000;
    mem_wdata = in_access ? wdata_l_q : 16'h0000;
  end

  // Request latch, response pulses, read capture and starvation counter.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_l_d       = we_l_q;
    bad_l_d      = bad_l_q;
    addr_l_d     = addr_l_q;
    wdata_l_d    = wdata_l_q;
    rdata_d      = rdata_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    if (start) begin
      owner_d      = winner;
      last_owner_d = winner;
      we_l_d       = winner ? we1    : we0;
      addr_l_d     = winner ? addr1  : addr0;
      wdata_l_d    = winner ? wdata1 : wdata0;
      bad_l_d      = addr_bad(winner ? addr1 : addr0);
    end

    if (in_access) begin
      rvalid0_d = ~owner_q & ~we_l_q & ~bad_l_q;
      rvalid1_d =  owner_q & ~we_l_q & ~bad_l_q;
      err0_d    = ~owner_q & bad_l_q;
      err1_d    =  owner_q & bad_l_q;
      // Writes leave rdata alone; an illegal read reports zero.
      if (!we_l_q) rdata_d = bad_l_q ? 16'h0000 : mem_rdata;
    end

    if (!req1 || (start && winner)) wait_cnt_d = 8'd0;
    else if (wait_cnt_q != 8'hFF)   wait_cnt_d = wait_cnt_q + 8'd1;
    else                            wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_l_q       <= 1'b0;
      bad_l_q      <= 1'b0;
      addr_l_q     <= 16'h0000;
      wdata_l_q    <= 16'h0000;
      rdata_q      <= 16'h0000;
      wait_cnt_q   <= 8'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_l_q       <= we_l_d;
      bad_l_q      <= bad_l_d;
      addr_l_q     <= addr_l_d;
      wdata_l_q    <= wdata_l_d;
      rdata_q      <= rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule
